reg_file_dump: RTL
==================

Name: reg_file_dump

Overview:
- Sequential reader/initiator for the 8-bit register file; the register file itself only accepts clocked writes.
- On a start command it walks a contiguous range of register addresses, driving the register file's combinational read-address port.
- Each read byte is presented on a valid/ready output stream, and a mod-256 checksum of the transferred bytes is kept.
- Used for debug dump, context save and test readback.

Parameters:
- pw, 3, register-file address width; depth is 2**pw, and it must match the attached register file.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
- start  input  1  one-cycle command; accepted only in IDLE.
- abort  input  1  cancels an active dump.
- base_addr  input  pw  first address to read; sampled with start.
- count  input  pw+1  number of bytes to read, 0..2**pw; sampled with start.
- rd_addr  output  pw  to register-file read-address pointer; equals the internal pointer ptr.
- rd_data  input  8  from register-file read data (combinational in rd_addr).
- dout  output  8  stream data (registered).
- dout_valid  output  1  stream valid (registered).
- dout_ready  input  1  stream ready from consumer.
- busy  output  1  high in LOAD and SEND.
- done  output  1  one-cycle completion pulse.
- checksum  output  8  mod-256 sum of accepted bytes; stable from done until the next accepted start.

Behaviour:
- Reset (reset_n=0 at an edge), regardless of state:
  - state=IDLE; ptr, remaining, dout, checksum = 0.
  - dout_valid, busy, done = 0.
- Handshake:
  - A transfer occurs on an edge where dout_valid && dout_ready.
  - dout must hold stable while dout_valid=1 and dout_ready=0.
  - dout_valid never drops without a transfer, except on abort or reset.
- IDLE:
  - start=1 with count!=0: ptr<=base_addr, remaining<=count, checksum<=0, go LOAD.
  - start=1 with count==0: checksum<=0, go DONE.
  - abort is ignored in IDLE.
- LOAD:
  - dout<=rd_data (the byte at ptr), dout_valid<=1, ptr<=ptr+1, remaining<=remaining-1, go SEND.
- SEND (dout_valid=1):
  - On a transfer, checksum<=checksum+dout (8-bit wrap).
  - If remaining==0: dout_valid<=0, go DONE.
  - Else: dout<=rd_data, ptr<=ptr+1, remaining<=remaining-1, stay in SEND. This gives back-to-back throughput of 1 byte/cycle.
  - No transfer: hold all state.
- DONE: done=1 for exactly this one cycle, busy=0, next state IDLE. start is ignored in DONE.
- Abort: abort=1 in LOAD or SEND goes to IDLE at the next edge.
  - dout_valid<=0, no done pulse, checksum holds its partial value.
  - abort has priority over a simultaneous transfer; that byte does not count.
- start while busy or in DONE: ignored, and parameters are not resampled.
- Address wrap: ptr increments modulo 2**pw, so base=6, count=4 reads 6,7,0,1.
- Latency: start accepted at edge E gives dout_valid=1 from edge E+2. The last transfer at edge T gives done=1 in the cycle after T.
- Concurrent register-file write: the byte captured is the combinational read value at the capture edge. A write to the same address on the same edge is not seen (old value).
- reset_n has priority over abort, and abort over start.

Decomposition:
- Package reg_file_dump_pkg:
  - typedef enum logic[1:0] {IDLE, LOAD, SEND, DONE} dump_state_t;
  - constant DATA_W=8.
- No sub-module. Single always_ff for state and datapath, plus always_comb for next-state and Moore outputs (busy, done, rd_addr).

Test Plan:
- Setup for all scenarios: pw=3, register file preloaded core[i]=8'h10+i, dout_ready=1 unless stated.
- Basic: start, base=2, count=3 -> dout 8'h12, 8'h13, 8'h14 on consecutive cycles; valid first at E+2; done pulse 1 cycle; checksum=8'h39.
- Wrap: base=6, count=4 -> 8'h16, 8'h17, 8'h10, 8'h11; checksum=8'h4E.
- Full dump: base=0, count=8 -> 8'h10..8'h17; checksum=8'h9C.
- Backpressure: base=0, count=3, dout_ready pattern 0,0,1,0,1,1 -> dout held stable while stalled; exactly 3 transfers 8'h10, 8'h11, 8'h12; done after the 3rd.
- Zero count and ignored start:
  - start with count=0 -> no dout_valid; done pulse in the cycle after the start edge; checksum=0.
  - A second start while busy is ignored.
- Abort and reset mid-run: base=0, count=8, abort after 2 transfers -> IDLE, dout_valid=0, no done, checksum=8'h21. Repeat with reset_n=0 instead -> all outputs 0. A following start still works.

Source files
------------

// File: rtl/reg_file_dump_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_file_dump_pkg                                         |
// | Purpose  : Shared types and constants for the register-file dump     |
// |            engine (state encoding, stream data width).               |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package reg_file_dump_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } dump_state_t;

endpackage : reg_file_dump_pkg
`default_nettype wire

// File: rtl/reg_file_dump.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reg_file_dump                                             |
// | Purpose  : Walks a contiguous (wrapping) address range of an 8-bit   |
// |            register file through its combinational read port and     |
// |            streams each byte out on a valid/ready interface, keeping |
// |            a mod-256 checksum of the bytes actually transferred.     |
// | Ports    : clk, reset_n (sync, active low)                           |
// |            start, abort, base_addr[pw], count[pw+1]  - command       |
// |            rd_addr[pw] -> / rd_data[8] <-            - reg file port |
// |            dout[8], dout_valid -> / dout_ready <-    - byte stream   |
// |            busy, done, checksum[8]                   - status        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module reg_file_dump
   import reg_file_dump_pkg::*;
#(
   parameter int pw = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [pw-1:0]     base_addr,
   input  logic [pw:0]       count,
   output logic [pw-1:0]     rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   localparam logic [pw-1:0] c_ptr_one = 1;
   localparam logic [pw:0]   c_rem_one = 1;
   localparam logic [pw:0]   c_rem_zero = '0;

   dump_state_t   r_state;
   dump_state_t   w_state_nxt;
   logic [pw-1:0] r_ptr;
   logic [pw:0]   r_remaining;
   logic          w_xfer;

   assign w_xfer = dout_valid && dout_ready;

   // Next-state and Moore outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      rd_addr     = r_ptr;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nxt = (count != c_rem_zero) ? LOAD : DONE;
            end
         end
         LOAD: begin
            busy        = 1'b1;
            w_state_nxt = abort ? IDLE : SEND;
         end
         SEND: begin
            busy = 1'b1;
            // abort wins over a transfer on the same edge
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (w_xfer && (r_remaining == c_rem_zero)) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and datapath
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_remaining <= '0;
         dout        <= '0;
         dout_valid  <= 1'b0;
         checksum    <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  checksum <= '0;
                  if (count != c_rem_zero) begin
                     r_ptr       <= base_addr;
                     r_remaining <= count;
                  end
               end
            end
            LOAD: begin
               if (abort) begin
                  dout_valid <= 1'b0;
               end else begin
                  dout        <= rd_data;
                  dout_valid  <= 1'b1;
                  r_ptr       <= r_ptr + c_ptr_one;
                  r_remaining <= r_remaining - c_rem_one;
               end
            end
            SEND: begin
               if (abort) begin
                  dout_valid <= 1'b0;
               end else if (w_xfer) begin
                  checksum <= checksum + dout;
                  if (r_remaining == c_rem_zero) begin
                     dout_valid <= 1'b0;
                  end else begin
                     // Next byte is fetched in the same cycle the current
                     // one leaves, giving one byte per clock when ready.
                     dout        <= rd_data;
                     r_ptr       <= r_ptr + c_ptr_one;
                     r_remaining <= r_remaining - c_rem_one;
                  end
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule : reg_file_dump
`default_nettype wire
